// File: rtl/spy_event_reader.sv
// Readout engine for the spy buffer: walks the event list backward from the newest
// entry, locates the selected event and streams its words out over valid/ready.
module spy_event_reader #(
    parameter int DATAWIDTH = 64,
    parameter int MEMWIDTH  = 6,
    parameter int METAWIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frozen,
    input  logic                 req,
    input  logic [METAWIDTH-1:0] evt_sel,
    input  logic [METAWIDTH-1:0] meta_write_addr,
    input  logic [METAWIDTH:0]   meta_fill,
    input  logic [MEMWIDTH:0]    meta_read_data,
    input  logic [MEMWIDTH-1:0]  mem_wptr,
    input  logic [DATAWIDTH:0]   data_in,
    output logic [METAWIDTH-1:0] meta_read_addr,
    output logic                 meta_read_enable,
    output logic [MEMWIDTH-1:0]  read_addr,
    output logic                 read_enable,
    output logic [DATAWIDTH:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err
);

    localparam logic [METAWIDTH-1:0] META_ONE = {{(METAWIDTH-1){1'b0}}, 1'b1};
    localparam logic [METAWIDTH:0]   WALK_ONE = {{METAWIDTH{1'b0}}, 1'b1};
    localparam logic [MEMWIDTH-1:0]  ADDR_ONE = {{(MEMWIDTH-1){1'b0}}, 1'b1};
    localparam logic [MEMWIDTH-1:0]  ADDR_ZERO = '0;
    localparam logic [MEMWIDTH:0]    REM_ONE  = {{MEMWIDTH{1'b0}}, 1'b1};
    localparam logic [MEMWIDTH:0]    REM_FULL = {1'b1, {MEMWIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, META_RD, META_WAIT, CHECK, DATA_RD, DATA_WAIT, OUT, DONE
    } state_t;

    state_t               state;
    logic [METAWIDTH-1:0] sel;
    logic [METAWIDTH-1:0] ptr;
    logic [METAWIDTH:0]   walked;
    logic [METAWIDTH:0]   found;
    logic [1:0]           sentinels;
    logic [MEMWIDTH-1:0]  end_addr;
    logic [MEMWIDTH-1:0]  start_addr;
    logic [MEMWIDTH-1:0]  addr;
    logic [MEMWIDTH:0]    remaining;

    logic                 entry_sentinel;
    logic [MEMWIDTH-1:0]  entry_addr;
    logic [METAWIDTH:0]   walked_next;
    logic [METAWIDTH-1:0] ptr_prev;
    logic [MEMWIDTH-1:0]  span;
    logic [MEMWIDTH-1:0]  addr_next;
    logic                 overwritten;

    assign entry_sentinel = meta_read_data[MEMWIDTH];
    assign entry_addr     = meta_read_data[MEMWIDTH-1:0];
    assign walked_next    = walked + WALK_ONE;
    assign ptr_prev       = ptr - META_ONE;
    assign span           = end_addr - start_addr;
    assign addr_next      = addr + ADDR_ONE;
    // A second wrap, or one wrap that has already eaten into the event's start, means lost data.
    assign overwritten    = (sentinels == 2'd2) ||
                            ((sentinels == 2'd1) && (start_addr < mem_wptr));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            sel              <= '0;
            ptr              <= '0;
            walked           <= '0;
            found            <= '0;
            sentinels        <= '0;
            end_addr         <= '0;
            start_addr       <= '0;
            addr             <= '0;
            remaining        <= '0;
            meta_read_addr   <= '0;
            meta_read_enable <= 1'b0;
            read_addr        <= '0;
            read_enable      <= 1'b0;
            out_data         <= '0;
            out_valid        <= 1'b0;
            out_last         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 2'd0;
        end else begin
            meta_read_enable <= 1'b0;
            read_enable      <= 1'b0;
            done             <= 1'b0;
            // Losing the freeze invalidates everything in flight; DONE has already reported.
            if (state != IDLE && state != DONE && !frozen) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
                err       <= 2'd3;
            end else begin
                case (state)
                    IDLE: begin
                        if (req && frozen) begin
                            sel              <= evt_sel;
                            ptr              <= meta_write_addr - META_ONE;
                            walked           <= '0;
                            found            <= '0;
                            sentinels        <= '0;
                            end_addr         <= mem_wptr;
                            err              <= 2'd0;
                            busy             <= 1'b1;
                            meta_read_enable <= 1'b1;
                            meta_read_addr   <= meta_write_addr - META_ONE;
                            state            <= META_RD;
                        end else if (req) begin
                            done <= 1'b1;
                            err  <= 2'd3;
                        end
                    end
                    META_RD: state <= META_WAIT;
                    META_WAIT: begin
                        walked <= walked_next;
                        if (!entry_sentinel && (found == {1'b0, sel})) begin
                            start_addr <= entry_addr;
                            state      <= CHECK;
                        end else begin
                            if (entry_sentinel) begin
                                if (sentinels != 2'd2) sentinels <= sentinels + 2'd1;
                            end else begin
                                end_addr <= entry_addr;
                                found    <= found + WALK_ONE;
                            end
                            ptr <= ptr_prev;
                            if (walked_next >= meta_fill) begin
                                done  <= 1'b1;
                                err   <= 2'd1;
                                state <= DONE;
                            end else begin
                                meta_read_enable <= 1'b1;
                                meta_read_addr   <= ptr_prev;
                                state            <= META_RD;
                            end
                        end
                    end
                    CHECK: begin
                        if (overwritten) begin
                            done  <= 1'b1;
                            err   <= 2'd2;
                            state <= DONE;
                        end else if (span == ADDR_ZERO && sentinels == 2'd0) begin
                            done  <= 1'b1;
                            err   <= 2'd1;
                            state <= DONE;
                        end else begin
                            // Zero span across one wrap means the event fills the whole buffer.
                            remaining   <= (span == ADDR_ZERO) ? REM_FULL : {1'b0, span};
                            addr        <= start_addr;
                            read_enable <= 1'b1;
                            read_addr   <= start_addr;
                            state       <= DATA_RD;
                        end
                    end
                    DATA_RD: state <= DATA_WAIT;
                    DATA_WAIT: begin
                        out_data  <= data_in;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == REM_ONE);
                        state     <= OUT;
                    end
                    OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            addr      <= addr_next;
                            remaining <= remaining - REM_ONE;
                            if (remaining == REM_ONE) begin
                                done  <= 1'b1;
                                err   <= 2'd0;
                                state <= DONE;
                            end else begin
                                read_enable <= 1'b1;
                                read_addr   <= addr_next;
                                state       <= DATA_RD;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spy_event_reader.sv
// Randomized self-checking bench for spy_event_reader: models both memories and
// predicts each readout from the event-list rules.
module tb_spy_event_reader;

    localparam int DW = 64;
    localparam int MW = 6;
    localparam int TW = 4;
    localparam int W  = DW + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          frozen;
    logic          req;
    logic [TW-1:0] evt_sel;
    logic [TW-1:0] meta_write_addr;
    logic [TW:0]   meta_fill;
    logic [MW:0]   meta_read_data;
    logic [MW-1:0] mem_wptr;
    logic [DW:0]   data_in;
    logic [TW-1:0] meta_read_addr;
    logic          meta_read_enable;
    logic [MW-1:0] read_addr;
    logic          read_enable;
    logic [DW:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    logic [MW:0]   meta_mem [16];
    logic [DW:0]   spy_mem  [64];

    int checks = 0;
    int errors = 0;

    spy_event_reader #(.DATAWIDTH(DW), .MEMWIDTH(MW), .METAWIDTH(TW)) dut (
        .clock(clock), .reset(reset), .frozen(frozen), .req(req), .evt_sel(evt_sel),
        .meta_write_addr(meta_write_addr), .meta_fill(meta_fill),
        .meta_read_data(meta_read_data), .mem_wptr(mem_wptr), .data_in(data_in),
        .meta_read_addr(meta_read_addr), .meta_read_enable(meta_read_enable),
        .read_addr(read_addr), .read_enable(read_enable), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Both memories answer one cycle after their read strobe.
    always @(posedge clock) begin
        if (meta_read_enable) meta_read_data <= meta_mem[meta_read_addr];
        if (read_enable) data_in <= spy_mem[read_addr];
    end

    task automatic checkOutput(input string tag, input logic [DW:0] observed, input logic [DW:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int wa, input int fill, input int wptr);
        meta_write_addr = TW'(wa);
        meta_fill       = (TW+1)'(fill);
        mem_wptr        = MW'(wptr);
    endtask

    // Newest-first list of real events, each tagged with how many wraps lie above it.
    function automatic void modelEvent(input int sel, output int e_err, output int e_start,
                                       output int e_len, output int e_reads);
        int starts[$];
        int wraps_above[$];
        int sent;
        int idx;
        int end_a;
        logic [MW:0] ent;
        sent = 0; e_err = 0; e_start = 0; e_len = 0;
        e_reads = int'(meta_fill);
        for (int i = 0; i < int'(meta_fill); i++) begin
            idx = (int'(meta_write_addr) - 1 - i) & 15;
            ent = meta_mem[idx];
            if (ent[MW]) sent++;
            else begin
                starts.push_back(int'(ent[MW-1:0]));
                wraps_above.push_back(sent);
                if (starts.size() == sel + 1) begin
                    e_reads = i + 1;
                    break;
                end
            end
        end
        if (starts.size() <= sel) begin
            e_err = 1;
            return;
        end
        e_start = starts[sel];
        end_a   = (sel == 0) ? int'(mem_wptr) : starts[sel-1];
        if (wraps_above[sel] >= 2 || (wraps_above[sel] == 1 && e_start < int'(mem_wptr))) begin
            e_err = 2;
            return;
        end
        e_len = (end_a - e_start) & 63;
        if (e_len == 0) begin
            if (wraps_above[sel] == 1) e_len = 64;
            else e_err = 1;
        end
    endfunction

    task automatic pulseReq();
        @(negedge clock); req = 1'b1;
        @(negedge clock); req = 1'b0;
    endtask

    task automatic runRead(input int sel, input int ready_pct, input int stall_at, input string name);
        int e_err, e_start, e_len, e_reads;
        int n, reads, valid_seen, stall_left, last_acc;
        bit got_done, held;
        logic [DW:0] held_data;
        logic held_last;
        modelEvent(sel, e_err, e_start, e_len, e_reads);
        evt_sel = TW'(sel);
        n = 0; reads = 0; valid_seen = 0; stall_left = 5; last_acc = 0;
        got_done = 1'b0; held = 1'b0; held_data = '0; held_last = 1'b0;
        pulseReq();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (meta_read_enable) reads++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (out_valid) valid_seen++;
            if (held) begin
                checkOutput({name, " hold valid"}, W'(out_valid), W'(1));
                checkOutput({name, " hold data"}, out_data, held_data);
                checkOutput({name, " hold last"}, W'(out_last), W'(held_last));
            end
            if (stall_at >= 0 && n == stall_at && out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = ($urandom_range(99) < ready_pct);
            held = 1'b0;
            if (out_valid && out_ready) begin
                checkOutput({name, " word"}, out_data, spy_mem[(e_start + n) & 63]);
                checkOutput({name, " last"}, W'(out_last), W'(n == e_len - 1));
                if (ready_pct == 100 && stall_at < 0 && n > 0)
                    checkOutput({name, " word spacing"}, W'(cyc - last_acc), W'(3));
                last_acc = cyc;
                n++;
            end else if (out_valid) begin
                held = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end
            @(negedge clock);
        end
        out_ready = 1'b0;
        checkOutput({name, " done seen"}, W'(got_done), W'(1));
        checkOutput({name, " err"}, W'(err), W'(e_err));
        checkOutput({name, " word count"}, W'(n), W'((e_err == 0) ? e_len : 0));
        checkOutput({name, " meta reads"}, W'(reads), W'(e_reads));
        if (e_err != 0) checkOutput({name, " no valid"}, W'(valid_seen), W'(0));
        @(negedge clock);
        checkOutput({name, " done width"}, W'(done), W'(0));
        checkOutput({name, " idle busy"}, W'(busy), W'(0));
        checkOutput({name, " err held"}, W'(err), W'(e_err));
    endtask

    task automatic loadBaseList();
        for (int i = 0; i < 16; i++) meta_mem[i] = '0;
        meta_mem[0] = 7'h00;
        meta_mem[1] = 7'h0A;
        meta_mem[2] = 7'h14;
        applyStimulus(3, 3, 'h1E);
    endtask

    task automatic runAbort();
        int n;
        bit aborted;
        n = 0; aborted = 1'b0;
        loadBaseList();
        evt_sel = '0;
        out_ready = 1'b1;
        pulseReq();
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (out_valid && n == 3) begin
                frozen = 1'b0;
                out_ready = 1'b0;
                aborted = 1'b1;
                @(negedge clock);
                break;
            end
            if (out_valid && out_ready) n++;
            @(negedge clock);
        end
        checkOutput("abort reached word 4", W'(aborted), W'(1));
        checkOutput("abort valid", W'(out_valid), W'(0));
        checkOutput("abort done", W'(done), W'(1));
        checkOutput("abort err", W'(err), W'(3));
        checkOutput("abort busy", W'(busy), W'(0));
        frozen = 1'b1;
        @(negedge clock);
        checkOutput("abort done width", W'(done), W'(0));
    endtask

    task automatic runResetMidOp();
        bit streaming;
        streaming = 1'b0;
        loadBaseList();
        evt_sel = '0;
        out_ready = 1'b0;
        pulseReq();
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (out_valid) begin
                streaming = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkOutput("midreset streaming", W'(streaming), W'(1));
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midreset busy", W'(busy), W'(0));
        checkOutput("midreset valid", W'(out_valid), W'(0));
        checkOutput("midreset data", out_data, '0);
        checkOutput("midreset done", W'(done), W'(0));
        checkOutput("midreset err", W'(err), W'(0));
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset no done", W'(done), W'(0));
        checkOutput("midreset idle", W'(busy), W'(0));
    endtask

    initial begin
        logic [DW:0] w;
        frozen = 1'b1; req = 1'b0; out_ready = 1'b0; evt_sel = '0;
        for (int i = 0; i < 64; i++) begin
            w[31:0]  = $urandom;
            w[63:32] = $urandom;
            w[64]    = 1'($urandom);
            spy_mem[i] = w;
        end
        loadBaseList();

        repeat (3) @(negedge clock);
        checkOutput("reset busy", W'(busy), W'(0));
        checkOutput("reset done", W'(done), W'(0));
        checkOutput("reset err", W'(err), W'(0));
        checkOutput("reset valid", W'(out_valid), W'(0));
        checkOutput("reset last", W'(out_last), W'(0));
        checkOutput("reset meta strobe", W'(meta_read_enable), W'(0));
        checkOutput("reset read strobe", W'(read_enable), W'(0));
        checkOutput("reset data", out_data, '0);
        reset = 1'b1;
        @(negedge clock);

        runRead(0, 100, -1, "newest");
        runRead(1, 100, -1, "second");
        runRead(3, 100, -1, "notfound");
        runRead(0, 100, 4, "stall");

        meta_mem[0] = 7'h30;
        meta_mem[1] = 7'h40;
        meta_mem[2] = 7'h08;
        applyStimulus(3, 3, 'h10);
        runRead(1, 100, -1, "wrap");
        applyStimulus(3, 3, 'h32);
        runRead(1, 100, -1, "overwritten");

        meta_mem[0] = 7'h10;
        meta_mem[1] = 7'h40;
        meta_mem[2] = 7'h10;
        applyStimulus(3, 3, 'h05);
        runRead(1, 100, -1, "fullbuffer");

        runAbort();

        frozen = 1'b0;
        pulseReq();
        checkOutput("unfrozen done", W'(done), W'(1));
        checkOutput("unfrozen err", W'(err), W'(3));
        checkOutput("unfrozen busy", W'(busy), W'(0));
        @(negedge clock);
        checkOutput("unfrozen done width", W'(done), W'(0));
        frozen = 1'b1;

        runResetMidOp();

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++)
                meta_mem[i] = ($urandom_range(99) < 20) ? 7'h40 : {1'b0, 6'($urandom)};
            applyStimulus(int'($urandom_range(15)), int'($urandom_range(16, 1)),
                          int'($urandom_range(63)));
            runRead(int'($urandom_range(5)), int'($urandom_range(100, 30)), -1, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
